// File: rtl/quad_comm_pkg.sv
// Shared types and constants for the QuadCopter serial command link.
package quad_comm_pkg;

    // Packet receive FSM states: waiting for cmd, data-high, data-low byte
    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } rx_state_t;

    // 50 MHz / 19200 baud, and ~40 ms inter-byte timeout
    localparam int BAUD_DIV_DEF = 2604;
    localparam int BYTE_TMO_DEF = 2_000_000;

    // Host command codes
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LND  = 8'h07;
    localparam logic [7:0] SET_MOFF  = 8'h08;

    // Positive acknowledge response
    localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Command/response handshake between the serial command receiver and
// the downstream command-config logic.
interface uart_cmd_wrapper_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    // Consumer side (command-config FSM)
    modport master (
        input  cmd, data, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );

    // Producer side (uart_cmd_wrapper)
    modport slave (
        output cmd, data, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_xcvr.sv
// Bit-level 8N1 UART: mid-bit sampling receiver and LSB-first transmitter.
// RX and TX run independently (full duplex).
module uart_xcvr #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV + BAUD_DIV / 2 + 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV + BAUD_DIV / 2 - 1);

    logic          rx_meta_q, rx_sync_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;

    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    // Receiver: synchronise RX, find start edge, sample 8 data bits and stop mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    // first sample lands in the middle of data bit 0
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF_BIT;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - CW'(1);
            end else begin
                rx_cnt_q <= FULL_BIT;
                if (rx_bit_q == 4'd8) begin
                    // stop-bit sample; a low stop bit drops the byte silently
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q) begin
                        rx_data_q <= rx_shift_q;
                        rx_rdy_q  <= 1'b1;
                    end
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end
        end
    end

    // Transmitter: shift out {stop, data, start} LSB first, one bit per BAUD_DIV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_done_q  <= 1'b0;
        end else if (!tx_busy_q) begin
            if (trmt) begin
                tx_shift_q <= {1'b1, tx_data, 1'b0};
                tx_busy_q  <= 1'b1;
                tx_cnt_q   <= FULL_BIT;
                tx_bit_q   <= '0;
                tx_done_q  <= 1'b0;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
        end else begin
            // ones shift in behind, so the line rests high after the stop bit
            tx_cnt_q   <= FULL_BIT;
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_done_q <= 1'b1;
            end else begin
                tx_bit_q <= tx_bit_q + 4'd1;
            end
        end
    end

    assign TX      = tx_shift_q[0];
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Packet layer on top of uart_xcvr: assembles cmd/data-high/data-low bytes
// into a command, drops stale partial packets, and forwards responses.
module uart_cmd_wrapper
    import quad_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int BYTE_TMO = BYTE_TMO_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RX,
    output logic                TX,
    uart_cmd_wrapper_if.slave   cif
);

    localparam int TW = $clog2(BYTE_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TMO - 1);

    logic [7:0]  rx_byte;
    logic        rx_rdy;

    rx_state_t   state_q, state_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // rx_rdy is acknowledged immediately, making it a one-cycle pulse
    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_data    (rx_byte),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (rx_rdy),
        .tx_data    (cif.resp),
        .trmt       (cif.send_resp),
        .tx_done    (cif.resp_sent)
    );

    // Packet FSM, timeout counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            hi_q      <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            cmd_rdy_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            cmd_rdy_q <= cmd_rdy_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state: byte sequencing, stale-packet timeout, cmd_rdy set/clear
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        cmd_rdy_d = cmd_rdy_q;
        tmo_d     = tmo_q + TW'(1);

        if (cif.clr_cmd_rdy) cmd_rdy_d = 1'b0;
        if (rx_rdy || state_q == IDLE) tmo_d = '0;

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    // a new packet supersedes the one still being held
                    shadow_d  = rx_byte;
                    cmd_rdy_d = 1'b0;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_d    = rx_byte;
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    // set overrides a simultaneous clr_cmd_rdy
                    cmd_d     = shadow_q;
                    data_d    = {hi_q, rx_byte};
                    cmd_rdy_d = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cif.cmd     = cmd_q;
    assign cif.data    = data_q;
    assign cif.cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: host-side UART driver/receiver, vector table,
// directed corner sequences and a randomized run against a packet model.
module tb_uart_cmd_wrapper;
    import quad_comm_pkg::*;

    localparam int BD  = 16;
    localparam int TMO = 600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RX = 1'b1;
    logic TX;

    uart_cmd_wrapper_if cif();

    uart_cmd_wrapper #(.BAUD_DIV(BD), .BYTE_TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .cif   (cif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  c, h, l;
        logic [7:0]  ec;
        logic [15:0] ed;
    } vec_t;
    vec_t vecs[5];

    // reference packet model: bytes accumulate, every third completes a packet
    logic [7:0]  mq[$];
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_rdy;

    function automatic void model_push(input logic [7:0] b);
        mq.push_back(b);
        if (mq.size() == 1) m_rdy = 1'b0;
        if (mq.size() == 3) begin
            m_cmd  = mq[0];
            m_data = {mq[1], mq[2]};
            m_rdy  = 1'b1;
            mq.delete();
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = f[i];
            repeat (BD - 1) @(negedge clk);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int n;
        n = 0;
        b = '0;
        ok = 1'b0;
        while (TX !== 1'b0 && n < 20 * BD) begin
            @(negedge clk);
            n++;
        end
        if (n < 20 * BD) begin
            repeat (BD / 2) @(negedge clk);
            ok = (TX === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                b[i] = TX;
            end
            repeat (BD) @(negedge clk);
            ok = ok && (TX === 1'b1);
        end
    endtask

    // Watch the low byte land: old values held through rx_rdy, new ones one clk later
    task automatic watch_load(input logic [7:0] old_c, input logic [15:0] old_d,
                              input logic [7:0] ec, input logic [15:0] ed);
        int n;
        n = 0;
        while (dut.rx_rdy !== 1'b1 && n < 20 * BD) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20 * BD) begin
            check("rx_rdy_seen", 32'(dut.rx_rdy), 32'd1);
        end else begin
            check("cmd_rdy_before_load", 32'(cif.cmd_rdy), 32'd0);
            check("cmd_held", 32'(cif.cmd), 32'(old_c));
            check("data_held", 32'(cif.data), 32'(old_d));
            @(negedge clk);
            check("cmd_rdy_latency", 32'(cif.cmd_rdy), 32'd1);
            check("cmd_loaded", 32'(cif.cmd), 32'(ec));
            check("data_loaded", 32'(cif.data), 32'(ed));
        end
    endtask

    task automatic send_packet(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                               input logic [7:0] old_c, input logic [15:0] old_d,
                               input logic [7:0] ec, input logic [15:0] ed);
        send_byte(c);
        send_byte(h);
        fork
            send_byte(l);
            watch_load(old_c, old_d, ec, ed);
        join
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        cif.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        cif.clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", 32'(cif.cmd_rdy), 32'd0);
    endtask

    task automatic tx_test(input logic [7:0] r, input logic [7:0] r2);
        logic [7:0] got;
        bit ok;
        int cyc;
        int hi_miss;
        @(negedge clk);
        cif.resp = r;
        cif.send_resp = 1'b1;
        @(negedge clk);
        cif.send_resp = 1'b0;
        check("resp_sent_cleared", 32'(cif.resp_sent), 32'd0);
        cyc = 0;
        fork
            recv_byte(got, ok);
            begin
                while (cif.resp_sent !== 1'b1 && cyc < 20 * BD) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            begin
                repeat (4 * BD) @(negedge clk);
                cif.resp = r2;
                cif.send_resp = 1'b1;
                @(negedge clk);
                cif.send_resp = 1'b0;
                cif.resp = r;
            end
        join
        check("tx_byte", 32'(got), 32'(r));
        check("tx_frame_ok", 32'(ok), 32'd1);
        checks++;
        if (cyc < 10 * BD - 2 || cyc > 10 * BD + 2) begin
            errors++;
            $display("FAIL resp_sent_time: got %0d cycles expected %0d +-2", cyc, 10 * BD);
        end
        hi_miss = 0;
        repeat (3 * BD) begin
            @(negedge clk);
            if (TX !== 1'b1) hi_miss++;
        end
        check("tx_idle_after", 32'(hi_miss), 32'd0);
        check("resp_sent_held", 32'(cif.resp_sent), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  old_c, c, h, l, got;
        logic [15:0] old_d;
        bit ok;
        int n, k;

        vecs[0] = '{c: SET_THRST, h: 8'h00, l: 8'hFF, ec: 8'h05, ed: 16'h00FF};
        vecs[1] = '{c: SET_ROLL,  h: 8'hFF, l: 8'h80, ec: 8'h03, ed: 16'hFF80};
        vecs[2] = '{c: SET_MOFF,  h: 8'hAA, l: 8'h55, ec: 8'h08, ed: 16'hAA55};
        vecs[3] = '{c: 8'h00,     h: 8'h00, l: 8'h00, ec: 8'h00, ed: 16'h0000};
        vecs[4] = '{c: 8'hFF,     h: 8'hFF, l: 8'hFF, ec: 8'hFF, ed: 16'hFFFF};

        cif.clr_cmd_rdy = 1'b0;
        cif.resp = '0;
        cif.send_resp = 1'b0;
        RX = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_TX", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cif.cmd), 32'd0);
        check("rst_data", 32'(cif.data), 32'd0);
        check("rst_cmd_rdy", 32'(cif.cmd_rdy), 32'd0);
        check("rst_resp_sent", 32'(cif.resp_sent), 32'd0);
        rst_n = 1'b1;
        repeat (2 * BD) @(negedge clk);

        // table-driven packets
        old_c = 8'h00;
        old_d = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            send_packet(vecs[i].c, vecs[i].h, vecs[i].l, old_c, old_d, vecs[i].ec, vecs[i].ed);
            if (i == 0) begin
                repeat (3 * BD) @(negedge clk);
                check("cmd_rdy_holds", 32'(cif.cmd_rdy), 32'd1);
            end
            clear_rdy();
            old_c = vecs[i].ec;
            old_d = vecs[i].ed;
        end

        // partial packet discarded by the inter-byte timeout
        send_byte(SET_PTCH);
        send_byte(8'h01);
        repeat (TMO + 10) @(negedge clk);
        check("tmo_no_rdy", 32'(cif.cmd_rdy), 32'd0);
        check("tmo_cmd_kept", 32'(cif.cmd), 32'hFF);
        check("tmo_data_kept", 32'(cif.data), 32'hFFFF);
        send_packet(SET_YAW, 8'h00, 8'h80, 8'hFF, 16'hFFFF, 8'h04, 16'h0080);
        clear_rdy();

        // response transmit, with an ignored send_resp mid-frame
        tx_test(POS_ACK, 8'h3C);
        tx_test(8'h5A, 8'hC3);

        // full duplex: packet arrives while responding; clr on the set cycle loses
        @(negedge clk);
        cif.resp = POS_ACK;
        cif.send_resp = 1'b1;
        @(negedge clk);
        cif.send_resp = 1'b0;
        fork
            recv_byte(got, ok);
            begin
                send_byte(8'h01);
                send_byte(8'hBE);
                cif.clr_cmd_rdy = 1'b1;
                fork
                    send_byte(8'hEF);
                    begin
                        n = 0;
                        while (cif.cmd_rdy !== 1'b1 && n < 20 * BD) begin
                            @(negedge clk);
                            n++;
                        end
                        cif.clr_cmd_rdy = 1'b0;
                    end
                join
            end
        join
        repeat (2) @(negedge clk);
        check("dup_set_wins", 32'(cif.cmd_rdy), 32'd1);
        check("dup_cmd", 32'(cif.cmd), 32'h01);
        check("dup_data", 32'(cif.data), 32'hBEEF);
        check("dup_tx_byte", 32'(got), 32'(POS_ACK));
        check("dup_tx_ok", 32'(ok), 32'd1);
        check("dup_resp_sent", 32'(cif.resp_sent), 32'd1);
        clear_rdy();

        // reset in the middle of a packet and a transmission
        send_packet(EMER_LND, 8'hAB, 8'hCD, 8'h01, 16'hBEEF, 8'h07, 16'hABCD);
        send_byte(8'h09);
        @(negedge clk);
        cif.resp = 8'h00;
        cif.send_resp = 1'b1;
        @(negedge clk);
        cif.send_resp = 1'b0;
        fork
            send_byte(8'h11);
            begin
                repeat (5 * BD) @(negedge clk);
                check("pre_rst_TX_busy", 32'(TX), 32'd0);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_TX", 32'(TX), 32'd1);
                check("mid_rst_cmd", 32'(cif.cmd), 32'd0);
                check("mid_rst_data", 32'(cif.data), 32'd0);
                check("mid_rst_cmd_rdy", 32'(cif.cmd_rdy), 32'd0);
                check("mid_rst_resp_sent", 32'(cif.resp_sent), 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BD) @(negedge clk);
        check("post_rst_TX", 32'(TX), 32'd1);
        send_packet(CALIBRATE, 8'h12, 8'h34, 8'h00, 16'h0000, 8'h06, 16'h1234);
        clear_rdy();

        // randomized packets, partial packets and responses against the model
        mq.delete();
        m_cmd = 8'h06;
        m_data = 16'h1234;
        m_rdy = 1'b0;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 2);
                for (int j = 0; j < k; j++) begin
                    c = 8'($urandom);
                    model_push(c);
                    send_byte(c);
                    repeat ($urandom_range(0, 2 * BD)) @(negedge clk);
                end
                repeat (TMO + 10) @(negedge clk);
                mq.delete();
                check("rnd_partial_rdy", 32'(cif.cmd_rdy), 32'(m_rdy));
                check("rnd_partial_cmd", 32'(cif.cmd), 32'(m_cmd));
                check("rnd_partial_data", 32'(cif.data), 32'(m_data));
            end
            c = 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            old_c = m_cmd;
            old_d = m_data;
            model_push(c);
            model_push(h);
            model_push(l);
            send_byte(c);
            repeat ($urandom_range(0, 2 * BD)) @(negedge clk);
            send_byte(h);
            repeat ($urandom_range(0, 2 * BD)) @(negedge clk);
            fork
                send_byte(l);
                watch_load(old_c, old_d, m_cmd, m_data);
            join
            check("rnd_rdy", 32'(cif.cmd_rdy), 32'(m_rdy));
            clear_rdy();
            m_rdy = 1'b0;
            if (it % 4 == 0) tx_test(8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Command receiver on the QuadCopter side of the serial link.
- Deserialises the 3-byte host packet (cmd, data high, data low) arriving on RX from the remote host UART.
- Presents cmd[7:0]/data[15:0] with a cmd_rdy flag to the downstream command-config FSM.
- Serialises a single-byte response (e.g. 8'hA5 ack) back to the host on TX. Sits between the serial pins and the command-config block.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit (50 MHz / 19200 baud).
- BYTE_TMO, 2_000_000: clk cycles allowed between packet bytes before the partial packet is discarded (~40 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial in from host; idles high
- TX  out  1  serial out to host; idles high
- cmd  out  8  command byte of last complete packet
- data  out  16  {high byte, low byte} of last complete packet
- cmd_rdy  out  1  complete packet held in cmd/data
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- resp  in  8  response byte to transmit
- send_resp  in  1  one-cycle pulse: start transmitting resp
- resp_sent  out  1  set when response stop bit completes; cleared by the next send_resp

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: TX=1, cmd=0, data=0, cmd_rdy=0, resp_sent=0, FSM=IDLE, timeout counter=0.
- RX is double-flopped before use. Receiver samples mid-bit: first sample at 1.5*BAUD_DIV after the start-bit falling edge, then every BAUD_DIV. 8N1, LSB first. rx_rdy pulses for one cycle when the stop bit is sampled.
- Receive FSM:
  - IDLE: on rx_rdy, capture byte as cmd_shadow, then go to WAIT_HI. Capturing a new cmd byte clears cmd_rdy in the same cycle (new packet supersedes the old one).
  - WAIT_HI: on rx_rdy, capture byte as hi_byte, then go to WAIT_LO.
  - WAIT_LO: on rx_rdy, load cmd<=cmd_shadow and data<={hi_byte,byte}. Set cmd_rdy on the following clk edge. Go to IDLE.
- cmd/data change only on that load edge; they are stable while cmd_rdy=1.
- Latency: cmd_rdy rises 1 clk after the low byte's rx_rdy pulse.
- Timeout: counter resets on every rx_rdy and while in IDLE. In WAIT_HI or WAIT_LO, reaching BYTE_TMO returns the FSM to IDLE and discards partial bytes. cmd/data/cmd_rdy are left untouched.
- clr_cmd_rdy in the same cycle as the cmd_rdy set edge: set wins. cmd_rdy stays 1.
- Framing error (stop bit sampled 0): byte dropped, no rx_rdy, FSM state unchanged.
- Transmitter:
  - send_resp while idle latches resp, clears resp_sent, then sends start, 8 data bits LSB first, and stop, each BAUD_DIV clk.
  - resp_sent is set on the cycle the stop bit period ends.
  - send_resp while a transmission is busy is ignored.
- RX and TX paths are fully independent: full duplex.
- Reset mid-packet or mid-transmission: immediate return to reset values. TX is forced high and any in-flight byte is lost.

Decomposition:
- Package quad_comm_pkg holds:
  - typedef enum {IDLE, WAIT_HI, WAIT_LO} rx_state_t
  - localparams BAUD_DIV_DEF and BYTE_TMO_DEF
  - command code constants SET_PTCH=8'h02 through SET_MOFF=8'h08
  - POS_ACK=8'hA5
- One sub-module, uart_xcvr: the bit-level 8N1 transmitter/receiver with rx_rdy/clr_rx_rdy and trmt/tx_done handshakes. uart_cmd_wrapper holds only the packet FSM, timeout counter and output registers.

Test Plan:
- Host sends 8'h05, 8'h00, 8'hFF -> cmd_rdy=1 one clk after the last rx_rdy, cmd=8'h05, data=16'h00FF. Stays 1 until clr_cmd_rdy, then 0.
- Host sends 8'h03, 8'hFF, 8'h80 -> cmd=8'h03, data=16'hFF80 (roll -128). Prior cmd/data held until the load edge.
- Host sends 8'h02 then 8'h01, then stalls BYTE_TMO+10 cycles, then sends 8'h04, 8'h00, 8'h80 -> no cmd_rdy after the stall. Final cmd=8'h04, data=16'h0080.
- Pulse send_resp with resp=8'hA5 -> host receives 8'hA5. resp_sent rises after 10*BAUD_DIV cycles (±2). A second send_resp mid-frame has no effect.
- Assert rst_n=0 midway through the data-high byte, release it, then send 8'h06, 8'h12, 8'h34 -> outputs at reset values during reset. Then cmd=8'h06, data=16'h1234, cmd_rdy=1.
- Host sends a full packet while a response is transmitting, with clr_cmd_rdy asserted on the set cycle -> both complete correctly and cmd_rdy=1 (set wins).
